// File: rtl/w2n_lane_sched.sv
// Round-robin scheduler sharing one narrow output lane among NUM_REQ wide-word
// requesters; each granted word is serialized LSB slice first over valid/ready.
module w2n_lane_sched #(
  parameter  int NUM_REQ  = 4,
  parameter  int WIDE_W   = 16,
  parameter  int NARROW_W = 8,
  localparam int RATIO    = WIDE_W / NARROW_W,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                        clk_narrow,
  input  logic                        rst_narrow_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WIDE_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [NARROW_W-1:0]         out_data,
  output logic                        out_last,
  output logic [IDX_W-1:0]            out_src,
  input  logic                        out_ready,
  output logic                        busy
);

  if ((WIDE_W % NARROW_W) != 0 || (WIDE_W / NARROW_W) < 2) begin : g_bad_ratio
    $error("w2n_lane_sched: WIDE_W must be an integer multiple >= 2 of NARROW_W");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("w2n_lane_sched: NUM_REQ must lie in 2..8");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [WIDE_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    scan;
  logic [IDX_W-1:0]    winner;
  logic                found;
  logic                last_beat;

  // Rotating priority scan: the requester just after the last grant wins ties.
  always_comb begin
    scan   = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && req_valid[scan]) begin
        found  = 1'b1;
        winner = scan;
      end
    end
  end

  assign last_beat = (beat_cnt_q == CNT_W'(RATIO - 1));

  always_ff @(posedge clk_narrow or negedge rst_narrow_n) begin
    if (!rst_narrow_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      shift_q      <= '0;
      src_q        <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      shift_q      <= shift_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    shift_d      = shift_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          shift_d      = req_data[winner*WIDE_W +: WIDE_W];
          src_d        = winner;
          last_grant_d = winner;
          beat_cnt_d   = '0;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_beat) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            shift_d    = shift_q >> NARROW_W;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The grant strobe is also gated by reset so nothing is accepted while held in reset.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && rst_narrow_n) req_ready[winner] = 1'b1;
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = last_beat;
      end
      default: ;
    endcase
  end

  assign out_data = shift_q[NARROW_W-1:0];
  assign out_src  = src_q;

endmodule

// File: tb/tb_w2n_lane_sched.sv
// Self-checking bench for w2n_lane_sched: directed scenarios plus random traffic,
// checked by a scoreboard fed from a word-level round-robin reference model.
module tb_w2n_lane_sched;

   localparam int NUM_REQ  = 4;
   localparam int WIDE_W   = 16;
   localparam int NARROW_W = 8;
   localparam int RATIO    = WIDE_W / NARROW_W;
   localparam int IDX_W    = 2;

   logic                      clk_narrow = 1'b0;
   logic                      rst_narrow_n = 1'b0;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*WIDE_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      out_valid;
   logic [NARROW_W-1:0]       out_data;
   logic                      out_last;
   logic [IDX_W-1:0]          out_src;
   logic                      out_ready;
   logic                      busy;

   typedef struct {
      logic [NARROW_W-1:0] data;
      logic                last;
      int                  src;
   } beat_t;

   beat_t expQ[$];
   int    nChecks = 0;
   int    nPass   = 0;

   // Requester-side intent: a pending word per requester, dropped once granted
   bit                pend [NUM_REQ];
   logic [WIDE_W-1:0] word [NUM_REQ];

   // Reference model: lane free/occupied, beats left in current word, last grantee
   bit mIdle = 1'b1;
   int mLeft = 0;
   int mLast = NUM_REQ - 1;

   w2n_lane_sched #(
      .NUM_REQ  (NUM_REQ),
      .WIDE_W   (WIDE_W),
      .NARROW_W (NARROW_W)
   ) dut (
      .clk_narrow   (clk_narrow),
      .rst_narrow_n (rst_narrow_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_src      (out_src),
      .out_ready    (out_ready),
      .busy         (busy)
   );

   // Free-running narrow clock
   always #5 clk_narrow = ~clk_narrow;

   // Single comparison point: every check counts toward the summary
   task automatic check(input string name, input int act, input int exp);
      nChecks++;
      if (act == exp) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Expected narrow beats of a word, least-significant slice first
   task automatic pushWord(input int src, input logic [WIDE_W-1:0] w);
      for (int b = 0; b < RATIO; b++) begin
         beat_t t;
         t.data = NARROW_W'(w >> (b * NARROW_W));
         t.last = (b == RATIO - 1);
         t.src  = src;
         expQ.push_back(t);
      end
   endtask

   // Next pending requester walking forward from the previous grantee, or -1
   function automatic int pickNext();
      int c = mLast;
      repeat (NUM_REQ) begin
         c = (c == NUM_REQ - 1) ? 0 : c + 1;
         if (pend[c]) return c;
      end
      return -1;
   endfunction

   task automatic resetModel();
      expQ.delete();
      mIdle = 1'b1;
      mLeft = 0;
      mLast = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
   endtask

   task automatic checkOutput(input logic [NUM_REQ-1:0] expRdy, input bit expBusy);
      check("req_ready", int'(req_ready), int'(expRdy));
      check("busy", int'(busy), int'(expBusy));
      check("out_valid", int'(out_valid), int'(expBusy));
   endtask

   task automatic checkResetValues();
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_last", int'(out_last), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_src", int'(out_src), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_req_ready", int'(req_ready), 0);
   endtask

   // Drive one cycle of inputs (called just after a falling edge) and advance the model
   task automatic applyStimulus(input bit rdy);
      logic [NUM_REQ-1:0] expRdy = '0;
      bit                 expBusy;
      int                 w;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = pend[i];
         req_data[i*WIDE_W +: WIDE_W] = word[i];
      end
      out_ready = rdy;
      expBusy = !mIdle;
      if (mIdle) begin
         w = pickNext();
         if (w >= 0) begin
            expRdy[w] = 1'b1;
            pushWord(w, word[w]);
            pend[w] = 1'b0;
            mLast   = w;
            mIdle   = 1'b0;
            mLeft   = RATIO;
         end
      end else if (rdy) begin
         mLeft--;
         if (mLeft == 0) mIdle = 1'b1;
      end
      #1 checkOutput(expRdy, expBusy);
   endtask

   task automatic runCycles(input int n, input bit rdy);
      repeat (n) begin
         @(negedge clk_narrow);
         applyStimulus(rdy);
      end
   endtask

   // Monitor: compare every presented beat with the scoreboard head, pop on acceptance
   always begin
      @(negedge clk_narrow);
      #2;
      if (rst_narrow_n && out_valid) begin
         check("beat_expected", int'(expQ.size() > 0), 1);
         if (expQ.size() > 0) begin
            check("out_data", int'(out_data), int'(expQ[0].data));
            check("out_last", int'(out_last), int'(expQ[0].last));
            check("out_src", int'(out_src), expQ[0].src);
            if (out_ready) void'(expQ.pop_front());
         end
      end
   end

   // Global watchdog so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int budget;
      bit drained;
      resetModel();
      for (int i = 0; i < NUM_REQ; i++) word[i] = '0;
      out_ready = 1'b0;
      req_data  = '0;
      req_valid = '1;
      #2;
      checkResetValues();
      req_valid = '0;
      @(negedge clk_narrow);
      rst_narrow_n = 1'b1;

      // Single word
      pend[0] = 1'b1; word[0] = 16'hA55A;
      runCycles(4, 1'b1);

      // Round robin with all four pending, then requester 0 again
      word[0] = 16'h1100; word[1] = 16'h3322; word[2] = 16'h5544; word[3] = 16'h7766;
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b1;
      runCycles(12, 1'b1);
      pend[0] = 1'b1; word[0] = 16'h1100;
      runCycles(4, 1'b1);

      // Backpressure on the first beat
      pend[1] = 1'b1; word[1] = 16'hBEEF;
      runCycles(1, 1'b1);
      runCycles(3, 1'b0);
      runCycles(3, 1'b1);

      // Pointer fairness: after 2 is served, 0 beats 2
      pend[2] = 1'b1; word[2] = 16'h0202;
      runCycles(4, 1'b1);
      pend[0] = 1'b1; word[0] = 16'h1234;
      pend[2] = 1'b1; word[2] = 16'h5678;
      runCycles(7, 1'b1);

      // Reset after the first beat of a word
      pend[0] = 1'b1; word[0] = 16'hCAFE;
      runCycles(2, 1'b1);
      @(negedge clk_narrow);
      rst_narrow_n = 1'b0;
      resetModel();
      #1 checkResetValues();
      @(negedge clk_narrow);
      rst_narrow_n = 1'b1;
      runCycles(3, 1'b1);
      pend[0] = 1'b1; word[0] = 16'h0F0F;
      pend[3] = 1'b1; word[3] = 16'h3C3C;
      runCycles(7, 1'b1);

      // Random traffic with random backpressure
      repeat (400) begin
         @(negedge clk_narrow);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               word[i] = WIDE_W'($urandom);
            end
         end
         applyStimulus($urandom_range(0, 3) != 0);
      end

      // Drain everything outstanding
      budget = 60;
      drained = 1'b0;
      while (!drained && budget > 0) begin
         runCycles(1, 1'b1);
         budget--;
         drained = mIdle;
         for (int i = 0; i < NUM_REQ; i++) if (pend[i]) drained = 1'b0;
      end
      check("drain_done", int'(drained), 1);
      runCycles(2, 1'b1);
      check("scoreboard_empty", expQ.size(), 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
